// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among NUM_REQ byte requesters.
// Round-robin per packet; the owner keeps the port until last or lock timeout.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_BITS    = 8,
   parameter int LOCK_TIMEOUT = 255
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]           i_req_last,
   output logic [NUM_REQ-1:0]           o_req_ready,
   output logic [NUM_REQ-1:0]           o_grant,
   output logic [DATA_BITS-1:0]         o_tx_data,
   output logic                         o_tx_write,
   input  logic                         i_tx_busy,
   output logic                         o_active
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [7:0] LOCK_LIM = 8'(LOCK_TIMEOUT - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      LOCKED
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] own_idx;
   logic [IW-1:0] win_idx;
   logic [IW-1:0] win_lo;
   logic [IW-1:0] win_hi;
   logic [IW-1:0] sel_idx;
   logic          win_any;
   logic          win_hit;
   logic          last_q;
   logic [7:0]    lock_cnt;
   logic          accept;
   logic          rel_own;

   // Round-robin pick: lowest valid index at or above rr_ptr, else lowest.
   always_comb begin
      win_lo  = '0;
      win_hi  = '0;
      win_any = 1'b0;
      win_hit = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req_valid[i]) begin
            win_lo  = IW'(i);
            win_any = 1'b1;
            if (IW'(i) >= rr_ptr) begin
               win_hi  = IW'(i);
               win_hit = 1'b1;
            end
         end
      end
      win_idx = win_hit ? win_hi : win_lo;
      sel_idx = (state_q == LOCKED) ? own_idx : win_idx;
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, acceptance handshake and strobes.
   always_comb begin
      state_d     = state_q;
      o_req_ready = '0;
      accept      = 1'b0;
      rel_own     = 1'b0;
      o_tx_write  = (state_q == ISSUE);
      o_active    = (state_q != IDLE);
      unique case (state_q)
         IDLE: begin
            if (i_rst_n && win_any && !i_tx_busy) begin
               o_req_ready[win_idx] = 1'b1;
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (i_tx_busy) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!i_tx_busy) begin
               if (last_q) begin
                  rel_own = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (i_rst_n && i_req_valid[own_idx]) begin
               o_req_ready[own_idx] = 1'b1;
               accept  = 1'b1;
               state_d = ISSUE;
            end else if (lock_cnt == LOCK_LIM) begin
               rel_own = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Byte latch, ownership, round-robin pointer and lock timer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_tx_data <= '0;
         o_grant   <= '0;
         own_idx   <= '0;
         last_q    <= 1'b0;
         rr_ptr    <= '0;
         lock_cnt  <= '0;
      end else begin
         if (accept) begin
            o_tx_data <= i_req_data[sel_idx*DATA_BITS +: DATA_BITS];
            last_q    <= i_req_last[sel_idx];
            own_idx   <= sel_idx;
            o_grant   <= NUM_REQ'(1) << sel_idx;
         end
         if (rel_own) begin
            o_grant <= '0;
            rr_ptr  <= (own_idx == LAST_IDX) ? '0 : own_idx + IW'(1);
         end
         if (state_q != LOCKED || accept) begin
            lock_cnt <= '0;
         end else begin
            lock_cnt <= lock_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors for the uart_tx arbiter.
// A small uart_tx model raises busy for three cycles after each write.
module tb_uart_tx_arbiter;

   localparam int LT = 12;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [3:0]  i_req_valid;
   logic [31:0] i_req_data;
   logic [3:0]  i_req_last;
   logic [3:0]  o_req_ready;
   logic [3:0]  o_grant;
   logic [7:0]  o_tx_data;
   logic        o_tx_write;
   logic        i_tx_busy;
   logic        o_active;

   logic busy_force = 1'b0;
   int   busy_cnt = 0;
   int   wr_cnt = 0;
   int   acc_cnt = 0;
   int   checks = 0;
   int   errors = 0;

   uart_tx_arbiter #(
      .NUM_REQ(4),
      .DATA_BITS(8),
      .LOCK_TIMEOUT(LT)
   ) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid),
      .i_req_data(i_req_data),
      .i_req_last(i_req_last),
      .o_req_ready(o_req_ready),
      .o_grant(o_grant),
      .o_tx_data(o_tx_data),
      .o_tx_write(o_tx_write),
      .i_tx_busy(i_tx_busy),
      .o_active(o_active)
   );

   always #5 i_clk = ~i_clk;

   assign i_tx_busy = busy_force | (busy_cnt > 0);

   always @(negedge i_clk) begin
      if (o_tx_write) begin
         wr_cnt = wr_cnt + 1;
         busy_cnt = 3;
      end else if (busy_cnt > 0) begin
         busy_cnt = busy_cnt - 1;
      end
   end

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  last;
      logic [3:0]  hold;
      logic [3:0]  pre_grant;
      logic [3:0]  exp_ready;
      logic [7:0]  exp_data;
      logic        wait_idle;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(output logic [3:0] r);
      int n;
      n = 0;
      #1;
      while (o_req_ready == 4'b0 && n < 100) begin
         @(negedge i_clk);
         #1;
         n++;
      end
      r = o_req_ready;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      #1;
      while (o_active && n < 100) begin
         @(negedge i_clk);
         #1;
         n++;
      end
      check("idle_active", 32'(o_active), 0);
      check("idle_grant", 32'(o_grant), 0);
   endtask

   task automatic post_accept(input logic [7:0] d,
                              input logic [3:0] g);
      check("write", 32'(o_tx_write), 1);
      check("tx_data", 32'(o_tx_data), 32'(d));
      check("grant", 32'(o_grant), 32'(g));
      check("active", 32'(o_active), 1);
   endtask

   initial begin
      logic [3:0] rdy;
      int w0;
      int k;
      logic seen;

      vecs[0] = '{4'b1111, 32'h44332211, 4'b1111, 4'b0000,
                  4'b0000, 4'b0001, 8'h11, 1'b1};
      vecs[1] = '{4'b1111, 32'h44332211, 4'b1111, 4'b0000,
                  4'b0000, 4'b0010, 8'h22, 1'b1};
      vecs[2] = '{4'b1111, 32'h44332211, 4'b1111, 4'b0000,
                  4'b0000, 4'b0100, 8'h33, 1'b1};
      vecs[3] = '{4'b1111, 32'h44332211, 4'b1111, 4'b0000,
                  4'b0000, 4'b1000, 8'h44, 1'b1};
      vecs[4] = '{4'b1111, 32'h44332211, 4'b1111, 4'b0000,
                  4'b0000, 4'b0001, 8'h11, 1'b1};
      vecs[5] = '{4'b0001, 32'h00000055, 4'b0001, 4'b0000,
                  4'b0000, 4'b0001, 8'h55, 1'b1};
      vecs[6] = '{4'b0110, 32'h00B2A100, 4'b0100, 4'b0100,
                  4'b0000, 4'b0010, 8'hA1, 1'b0};
      vecs[7] = '{4'b0110, 32'h00B2A200, 4'b0110, 4'b0100,
                  4'b0010, 4'b0010, 8'hA2, 1'b0};
      vecs[8] = '{4'b0100, 32'h00B20000, 4'b0100, 4'b0000,
                  4'b0000, 4'b0100, 8'hB2, 1'b1};

      i_rst_n     = 1'b0;
      i_req_valid = 4'b1111;
      i_req_data  = 32'hFFFFFFFF;
      i_req_last  = 4'b1111;
      #12;
      check("rst_ready", 32'(o_req_ready), 0);
      check("rst_grant", 32'(o_grant), 0);
      check("rst_write", 32'(o_tx_write), 0);
      check("rst_active", 32'(o_active), 0);
      check("rst_data", 32'(o_tx_data), 0);
      i_req_valid = 4'b0000;
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      for (int v = 0; v < 9; v++) begin
         i_req_valid = vecs[v].valid;
         i_req_data  = vecs[v].data;
         i_req_last  = vecs[v].last;
         wait_ready(rdy);
         check($sformatf("v%0d_ready", v), 32'(rdy),
               32'(vecs[v].exp_ready));
         check($sformatf("v%0d_pre_grant", v), 32'(o_grant),
               32'(vecs[v].pre_grant));
         w0 = wr_cnt;
         @(negedge i_clk);
         acc_cnt++;
         i_req_valid = vecs[v].hold;
         post_accept(vecs[v].exp_data, vecs[v].exp_ready);
         if (vecs[v].wait_idle) begin
            wait_idle();
            check($sformatf("v%0d_one_write", v), 32'(wr_cnt - w0), 1);
         end
      end

      i_req_valid = 4'b1000;
      i_req_data  = 32'h3C00000F;
      i_req_last  = 4'b0001;
      wait_ready(rdy);
      check("to_ready3", 32'(rdy), 32'(4'b1000));
      @(negedge i_clk);
      acc_cnt++;
      i_req_valid = 4'b0001;
      post_accept(8'h3C, 4'b1000);
      k = 0;
      #1;
      while (o_req_ready == 4'b0 && k < LT + 40) begin
         @(negedge i_clk);
         #1;
         k++;
         if (k == LT + 3) begin
            check("to_locked_grant", 32'(o_grant), 32'(4'b1000));
         end
      end
      check("to_release_cycles", 32'(k), 32'(LT + 4));
      check("to_ready0", 32'(o_req_ready), 32'(4'b0001));
      @(negedge i_clk);
      acc_cnt++;
      i_req_valid = 4'b0000;
      post_accept(8'h0F, 4'b0001);
      wait_idle();

      i_req_valid = 4'b0100;
      i_req_data  = 32'h00990000;
      i_req_last  = 4'b0100;
      wait_ready(rdy);
      check("rs_ready2", 32'(rdy), 32'(4'b0100));
      @(negedge i_clk);
      acc_cnt++;
      i_req_valid = 4'b0000;
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b0;
      i_req_valid = 4'b1001;
      #1;
      w0 = wr_cnt;
      check("rs_grant", 32'(o_grant), 0);
      check("rs_write", 32'(o_tx_write), 0);
      check("rs_active", 32'(o_active), 0);
      check("rs_ready", 32'(o_req_ready), 0);
      check("rs_data", 32'(o_tx_data), 0);
      @(negedge i_clk);
      #1;
      check("rs_ready_held", 32'(o_req_ready), 0);
      i_req_valid = 4'b0000;
      #1;
      i_rst_n = 1'b1;
      repeat (6) @(negedge i_clk);
      #1;
      check("rs_no_write", 32'(wr_cnt - w0), 0);
      check("rs_idle", 32'(o_active), 0);
      i_req_valid = 4'b1001;
      i_req_data  = 32'h000000A5;
      i_req_last  = 4'b1001;
      wait_ready(rdy);
      check("rs_rr_reset", 32'(rdy), 32'(4'b0001));
      @(negedge i_clk);
      acc_cnt++;
      i_req_valid = 4'b0000;
      post_accept(8'hA5, 4'b0001);
      wait_idle();

      busy_force  = 1'b1;
      i_req_valid = 4'b0001;
      i_req_data  = 32'h0000005A;
      i_req_last  = 4'b0001;
      seen = 1'b0;
      repeat (8) begin
         @(negedge i_clk);
         #1;
         if (o_req_ready != 4'b0 || o_tx_write) seen = 1'b1;
      end
      check("bz_blocked", 32'(seen), 0);
      check("bz_active", 32'(o_active), 0);
      busy_force = 1'b0;
      wait_ready(rdy);
      check("bz_ready", 32'(rdy), 32'(4'b0001));
      @(negedge i_clk);
      acc_cnt++;
      i_req_valid = 4'b0000;
      post_accept(8'h5A, 4'b0001);
      wait_idle();

      check("total_writes", 32'(wr_cnt), 32'(acc_cnt));

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters sharing one uart_tx (2..8).
REQ-002 SHALL have parameter DATA_BITS, default 8, byte width; matches uart_tx DATA_BITS.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 255, idle cycles before a held packet lock is force-released (1..255).
REQ-004 SHALL have port i_clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_req_valid  input  NUM_REQ  per-requester byte-valid.
REQ-007 SHALL have port i_req_data  input  NUM_REQ*DATA_BITS  per-requester byte; requester k at bits [k*DATA_BITS +: DATA_BITS].
REQ-008 SHALL have port i_req_last  input  NUM_REQ  per-requester end-of-packet flag, qualified by valid.
REQ-009 SHALL have port o_req_ready  output  NUM_REQ  one-hot acceptance pulse; byte transfers when valid and ready are high on the same edge.
REQ-010 SHALL have port o_grant  output  NUM_REQ  one-hot current owner; zero when no owner.
REQ-011 SHALL have port o_tx_data  output  DATA_BITS  byte to uart_tx i_data.
REQ-012 SHALL have port o_tx_write  output  1  one-cycle write strobe to uart_tx i_write.
REQ-013 SHALL have port i_tx_busy  input  1  uart_tx o_busy.
REQ-014 SHALL have port o_active  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, LOCKED.
REQ-016 IDLE: if any i_req_valid and i_tx_busy=0, SHALL pick winner by round-robin from pointer rr_ptr (lowest index >= rr_ptr, wrapping), assert o_req_ready[winner] combinationally that cycle, latch byte into o_tx_data, set o_grant, go ISSUE; else stay IDLE with o_req_ready=0.
REQ-017 IDLE with i_tx_busy=1 (external/prior use) SHALL accept nothing.
REQ-018 ISSUE: SHALL drive o_tx_write=1 for exactly one cycle, go WAIT_BUSY.
REQ-019 WAIT_BUSY: SHALL stay until i_tx_busy=1, then go WAIT_DONE.
REQ-020 WAIT_DONE: on i_tx_busy=0, SHALL go IDLE if the accepted byte had last=1, else LOCKED.
REQ-021 On packet end (transition to IDLE from WAIT_DONE or timeout), SHALL set rr_ptr = (owner+1) mod NUM_REQ and clear o_grant.
REQ-022 LOCKED: only owner may be accepted; if i_req_valid[owner]=1, SHALL pulse o_req_ready[owner], latch byte, go ISSUE; other requesters' ready SHALL stay 0.
REQ-023 LOCKED: 8-bit counter SHALL count cycles with owner valid low; reaching LOCK_TIMEOUT SHALL release to IDLE per REQ-021; counter clears on entry to LOCKED and on acceptance.
REQ-024 o_tx_data SHALL remain stable from acceptance until next acceptance.
REQ-025 At most one o_req_ready bit and one o_tx_write per byte; o_req_ready SHALL never assert outside IDLE/LOCKED.
REQ-026 Owner deasserting valid mid-packet SHALL not cancel the byte in flight.
REQ-027 rr_ptr SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-028 On i_rst_n=0, immediately: state IDLE, rr_ptr=0, o_grant=0, o_req_ready=0, o_tx_write=0, o_tx_data=0, o_active=0, timeout counter=0.
REQ-029 Reset asserted mid-transfer SHALL abort ownership; no write strobe after release until a new acceptance.
REQ-030 After reset release, first acceptance SHALL occur no earlier than the first rising edge with i_rst_n=1.

Verification
REQ-031 Req0 valid, data 0x55, last=1, busy low -> ready[0] pulse, write one cycle later with o_tx_data=0x55, back to IDLE, rr_ptr=1.
REQ-032 Req0..3 all valid, last=1, rr_ptr=0 -> service order 0,1,2,3,0; exactly one write per byte.
REQ-033 Req1 sends 0xA1(last=0), 0xA2(last=1) while req2 valid -> both req1 bytes before any req2 acceptance; o_grant=0b0010 throughout.
REQ-034 Req3 sends last=0 then drops valid -> release after LOCK_TIMEOUT cycles, req0 then served.
REQ-035 i_rst_n pulsed low while in WAIT_DONE -> all outputs zero asynchronously; no o_tx_write until new valid after release.
REQ-036 i_tx_busy held high, req0 valid -> no ready, no write, state IDLE, o_active=0.
